// File: rtl/shield_step_ctrl.sv
// Per-step sequencer between the learning agent and the 3-bit action shield:
// collects (or defaults) one action per tick, strobes the shield once, forwards the corrected action.
module shield_step_ctrl #(
    parameter int          TIMEOUT     = 16,
    parameter logic [2:0]  DEFAULT_ACT = 3'b000,
    parameter int          CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             tick,
    input  logic             act_valid,
    output logic             act_ready,
    input  logic [2:0]       act,
    output logic [2:0]       sh_act,
    input  logic [2:0]       sh_safe,
    output logic             sh_step,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_act,
    output logic             out_override,
    output logic             out_timeout,
    output logic [CNT_W-1:0] ovr_count,
    output logic [CNT_W-1:0] to_count,
    output logic             overrun,
    input  logic             clr_counts
);

    localparam int            TW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT_ACT, APPLY, OUTPUT} state_t;

    state_t            state_reg, state_next;
    logic [TW-1:0]     timer_reg;
    logic [2:0]        act_q_reg;
    logic              to_q_reg;
    logic [2:0]        out_act_reg;
    logic              out_override_reg;
    logic              out_timeout_reg;
    logic [CNT_W-1:0]  ovr_count_reg;
    logic [CNT_W-1:0]  to_count_reg;
    logic              overrun_reg;
    logic              override_now;
    logic              timer_expired;

    assign timer_expired = (timer_reg == T_LAST);
    assign override_now  = (sh_safe != act_q_reg);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (tick) state_next = WAIT_ACT;
            WAIT_ACT: if (act_valid || timer_expired) state_next = APPLY;
            APPLY:    state_next = OUTPUT;
            OUTPUT:   if (out_ready) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Handshake and strobe outputs decode straight from the state register so
    // an asynchronous reset drops them without waiting for a clock edge.
    assign act_ready    = (state_reg == WAIT_ACT);
    assign sh_step      = (state_reg == APPLY);
    assign out_valid    = (state_reg == OUTPUT);
    assign sh_act       = act_q_reg;
    assign out_act      = out_act_reg;
    assign out_override = out_override_reg;
    assign out_timeout  = out_timeout_reg;
    assign ovr_count    = ovr_count_reg;
    assign to_count     = to_count_reg;
    assign overrun      = overrun_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            timer_reg        <= '0;
            act_q_reg        <= DEFAULT_ACT;
            to_q_reg         <= 1'b0;
            out_act_reg      <= 3'b000;
            out_override_reg <= 1'b0;
            out_timeout_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (tick) timer_reg <= '0;
                end
                WAIT_ACT: begin
                    timer_reg <= timer_reg + 1'b1;
                    // An agent action in the final wait cycle beats the timeout.
                    if (act_valid) begin
                        act_q_reg <= act;
                        to_q_reg  <= 1'b0;
                    end else if (timer_expired) begin
                        act_q_reg <= DEFAULT_ACT;
                        to_q_reg  <= 1'b1;
                    end
                end
                APPLY: begin
                    out_act_reg      <= sh_safe;
                    out_override_reg <= override_now;
                    out_timeout_reg  <= to_q_reg;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovr_count_reg <= '0;
            to_count_reg  <= '0;
            overrun_reg   <= 1'b0;
        end else if (clr_counts) begin
            ovr_count_reg <= '0;
            to_count_reg  <= '0;
            overrun_reg   <= 1'b0;
        end else begin
            if (state_reg == APPLY) begin
                if (override_now && (ovr_count_reg != '1)) ovr_count_reg <= ovr_count_reg + 1'b1;
                if (to_q_reg && (to_count_reg != '1))      to_count_reg  <= to_count_reg + 1'b1;
            end
            if (tick && (state_reg != IDLE)) overrun_reg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_shield_step_ctrl.sv
// Scoreboard bench for shield_step_ctrl with a stub shield that can force overrides.
module tb_shield_step_ctrl;

    localparam int         TIMEOUT = 16;
    localparam logic [2:0] DEF     = 3'b000;
    localparam int         CNT_W   = 4;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             tick = 1'b0;
    logic             act_valid = 1'b0;
    logic             act_ready;
    logic [2:0]       act = 3'b000;
    logic [2:0]       sh_act;
    logic [2:0]       sh_safe;
    logic             sh_step;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [2:0]       out_act;
    logic             out_override;
    logic             out_timeout;
    logic [CNT_W-1:0] ovr_count;
    logic [CNT_W-1:0] to_count;
    logic             overrun;
    logic             clr_counts = 1'b0;

    logic ovr_mode = 1'b0;

    typedef struct {
        logic [2:0]       act;
        logic             ovr;
        logic             to;
        logic [CNT_W-1:0] oc;
        logic [CNT_W-1:0] tc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int steps_seen = 0;
    int steps_exp = 0;
    int m_ovr = 0;
    int m_to = 0;
    logic m_overrun = 1'b0;

    shield_step_ctrl #(.TIMEOUT(TIMEOUT), .DEFAULT_ACT(DEF), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset_n(reset_n), .tick(tick),
        .act_valid(act_valid), .act_ready(act_ready), .act(act),
        .sh_act(sh_act), .sh_safe(sh_safe), .sh_step(sh_step),
        .out_valid(out_valid), .out_ready(out_ready), .out_act(out_act),
        .out_override(out_override), .out_timeout(out_timeout),
        .ovr_count(ovr_count), .to_count(to_count), .overrun(overrun),
        .clr_counts(clr_counts)
    );

    always #5 clock = ~clock;

    // Stub shield: in override mode it forbids l2.
    function automatic logic [2:0] stub(input logic [2:0] x, input logic m);
        return m ? (x & 3'b101) : x;
    endfunction
    assign sh_safe = stub(sh_act, ovr_mode);

    always @(negedge clock) if (sh_step) steps_seen++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // delay = wait cycles before act_valid; delay >= TIMEOUT means no action at all.
    task automatic run_step(input logic [2:0] a, input int delay, input int bp,
                            input bit tick_wait, input bit tick_out, input bit clr_apply);
        logic [2:0] applied;
        exp_t e;
        int last;
        applied = (delay < TIMEOUT) ? a : DEF;
        e.act = stub(applied, ovr_mode);
        e.ovr = (e.act != applied);
        e.to  = (delay >= TIMEOUT);
        if (tick_wait) m_overrun = 1'b1;
        if (clr_apply) begin
            m_ovr = 0; m_to = 0; m_overrun = 1'b0;
        end else begin
            if (e.ovr && m_ovr != 15) m_ovr++;
            if (e.to && m_to != 15) m_to++;
        end
        if (tick_out) m_overrun = 1'b1;
        e.oc = CNT_W'(m_ovr);
        e.tc = CNT_W'(m_to);
        sb.push_back(e);

        @(negedge clock); tick = 1'b1;
        @(negedge clock); tick = 1'b0;
        steps_exp++;
        check("ready_after_tick", act_ready, 1);
        check("no_step_in_wait", sh_step, 0);
        last = (delay < TIMEOUT) ? delay : TIMEOUT - 1;
        for (int i = 0; i <= last; i++) begin
            if (i > 0) @(negedge clock);
            act = a;
            act_valid = (i == delay);
            tick = tick_wait && (i == 1);
        end
        @(negedge clock);
        act_valid = 1'b0;
        tick = 1'b0;
        check("apply_step", sh_step, 1);
        check("apply_sh_act", sh_act, applied);
        check("apply_no_valid", out_valid, 0);
        clr_counts = clr_apply;
        @(negedge clock);
        clr_counts = 1'b0;
        check("step_single", sh_step, 0);
        for (int j = 0; j < bp; j++) begin
            check("hold_valid", out_valid, 1);
            check("hold_act", out_act, sb[0].act);
            tick = tick_out && (j == 0);
            @(negedge clock);
            tick = 1'b0;
        end
        check("out_valid", out_valid, 1);
        out_ready = 1'b1;
        e = sb.pop_front();
        $display("step act=%b delay=%0d -> out_act=%b ovr=%b to=%b oc=%0d tc=%0d",
                 a, delay, out_act, out_override, out_timeout, ovr_count, to_count);
        check("out_act", out_act, e.act);
        check("out_override", out_override, e.ovr);
        check("out_timeout", out_timeout, e.to);
        check("ovr_count", ovr_count, e.oc);
        check("to_count", to_count, e.tc);
        @(negedge clock);
        out_ready = 1'b0;
        check("valid_drop", out_valid, 0);
        check("overrun", overrun, m_overrun);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, act_ready, 0);
        check({tag, "_step"}, sh_step, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_sh_act"}, sh_act, DEF);
        check({tag, "_out_act"}, {out_act, out_override, out_timeout}, 0);
        check({tag, "_counts"}, {ovr_count, to_count, overrun}, 0);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check_reset_values("rst");
        #2 reset_n = 1'b1;

        // Basic, override with backpressure, timeout, and timeout-cycle race.
        run_step(3'b011, 0, 0, 0, 0, 0);
        ovr_mode = 1'b1;
        run_step(3'b110, 0, 5, 0, 0, 0);
        ovr_mode = 1'b0;
        run_step(3'b111, TIMEOUT, 0, 0, 0, 0);
        run_step(3'b101, TIMEOUT - 1, 0, 0, 0, 0);

        // Ticks during WAIT_ACT and OUTPUT are dropped but flagged.
        run_step(3'b010, 3, 2, 1, 1, 0);
        check("overrun_single_step", steps_seen, steps_exp);

        @(negedge clock); clr_counts = 1'b1;
        @(negedge clock); clr_counts = 1'b0;
        m_ovr = 0; m_to = 0; m_overrun = 1'b0;
        check("clr_counts", {ovr_count, to_count, overrun}, 0);

        ovr_mode = 1'b1;
        run_step(3'b110, 1, 0, 0, 0, 1);
        for (int k = 0; k < 17; k++) run_step(3'b111, 0, 0, 0, 0, 0);
        check("saturated", ovr_count, 4'hF);
        ovr_mode = 1'b0;

        // Asynchronous reset landing inside APPLY.
        @(negedge clock); tick = 1'b1;
        @(negedge clock); tick = 1'b0; act_valid = 1'b1; act = 3'b011;
        @(negedge clock); act_valid = 1'b0;
        check("rst_apply_pre", sh_step, 1);
        steps_exp++;
        #2 reset_n = 1'b0;
        #1 check_reset_values("async_rst");
        @(negedge clock);
        #2 reset_n = 1'b1;
        m_ovr = 0; m_to = 0; m_overrun = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("idle_after_rst", {act_ready, sh_step, out_valid}, 0);
        end
        run_step(3'b001, 2, 1, 0, 0, 0);

        check("total_steps", steps_seen, steps_exp);
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shield_step_ctrl.md
# shield_step_ctrl

Per-step sequencer between the learning agent and the 3-bit action shield. Once per environment step it collects the agent's proposed action over a valid/ready handshake, or substitutes a default action on timeout. It then presents the action to the shield, strobes the shield's state advance exactly once, and hands the corrected action downstream with override/timeout flags. It also maintains saturating intervention statistics for the monitor.

## Interface
Parameters:
- TIMEOUT, 16: cycles to wait for an agent action after a tick before substituting the default (legal range ≥2).
- DEFAULT_ACT, 3'b000: action substituted on timeout.
- CNT_W, 16: width of statistics counters.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- tick  in  1  one-cycle environment step strobe.
- act_valid  in  1  agent action valid.
- act_ready  out  1  controller accepts an action.
- act  in  3  proposed action {l3,l2,l1}.
- sh_act  out  3  action driven to shield inputs {l3,l2,l1}.
- sh_safe  in  3  shield corrected output {l3__1,l2__1,l1__1}; combinational from sh_act.
- sh_step  out  1  shield state-register update enable; exactly one cycle per step.
- out_valid  out  1  corrected action valid.
- out_ready  in  1  downstream accepts.
- out_act  out  3  corrected action.
- out_override  out  1  out_act differs from the applied action.
- out_timeout  out  1  step used DEFAULT_ACT.
- ovr_count  out  CNT_W  steps with override, saturating.
- to_count  out  CNT_W  steps with timeout, saturating.
- overrun  out  1  sticky: tick arrived while not IDLE.
- clr_counts  in  1  synchronous clear of ovr_count, to_count, overrun.

## Operation
- FSM states: IDLE, WAIT_ACT, APPLY, OUTPUT.
- IDLE: act_ready=0. On tick, go to WAIT_ACT and load timer=0.
- WAIT_ACT: act_ready=1; timer increments each cycle.
  - act_valid=1: capture act into act_q, clear to_q, go to APPLY.
  - Otherwise, timer==TIMEOUT-1: act_q=DEFAULT_ACT, to_q=1, go to APPLY.
  - act_valid in the timeout cycle wins; the agent action is used and no timeout is recorded.
- APPLY (one cycle): sh_act=act_q; sh_step=1. Register out_act=sh_safe, out_override=(sh_safe!=act_q), out_timeout=to_q. Increment ovr_count if override and to_count if to_q, both saturating at all-ones. Go to OUTPUT.
- OUTPUT: out_valid=1; out_act, out_override and out_timeout stay stable until out_ready. On out_valid&&out_ready, return to IDLE.
- sh_act holds act_q outside APPLY (DEFAULT_ACT after reset). sh_step is 0 outside APPLY.
- A tick in any state other than IDLE is dropped and sets overrun; it does not restart the FSM.
- clr_counts zeroes both counters and overrun. If it coincides with an increment in APPLY, the clear wins and the count stays 0.
- Reset (async, any state): FSM=IDLE, act_ready=0, sh_step=0, out_valid=0, out_act=0, out_override=0, out_timeout=0, sh_act=DEFAULT_ACT, ovr_count=0, to_count=0, overrun=0, timer=0.
  - Reset during APPLY is safe because sh_step deasserts asynchronously.
  - The shield's own state is reset by its owner, not by this block.

## Timing
- tick at cycle T: act_ready=1 from T+1.
- Action accepted at cycle A (act_valid&&act_ready): APPLY at A+1 with sh_step=1; out_valid=1 from A+2.
- No action: timeout APPLY at T+1+TIMEOUT; out_valid at T+2+TIMEOUT.
- Minimum tick-to-out_valid latency is 3 cycles, when act_valid is already high at T+1.
- Counters update on the clock edge ending APPLY and are visible with out_valid.
- out_ready may be held high; the out_valid pulse is then one cycle. The next tick is accepted from the first IDLE cycle.
- At most one sh_step per accepted tick; zero sh_step without a tick.

## Test plan
- Basic step: tick at 0, act=3'b011 valid at 1, stub sh_safe=sh_act -> sh_step at cycle 2 only; out_act=3'b011, override=0, timeout=0, out_valid at 3; ovr_count=0.
- Override: act=3'b110, stub returns 3'b100 -> out_act=3'b100, out_override=1, ovr_count=1; out_act held stable through 5 cycles of out_ready=0 backpressure.
- Timeout: TIMEOUT=16, no act_valid after tick at 0 -> APPLY at 17 with sh_act=3'b000; out_timeout=1, out_valid at 18, to_count=1. Repeat with act_valid exactly at cycle 16 -> agent action used, to_count unchanged.
- Overrun: tick during WAIT_ACT and during OUTPUT -> overrun=1, single sh_step only; clr_counts -> overrun=0 and counters=0. clr_counts coinciding with an override APPLY -> ovr_count=0.
- Saturation: CNT_W=4, 17 override steps -> ovr_count stays 4'hF.
- Async reset mid-APPLY: reset_n low at the APPLY cycle -> sh_step, out_valid and act_ready drop immediately; after release, FSM idles until the next tick; all outputs at their reset values.
